// File: rtl/io_bridge_if.sv
// Bus bundle between the CPU data-memory port, the I/O bridge and the memory-mapped devices.
// The bridge takes the slave view; the CPU/device side (or a bench) takes the master view.
interface io_bridge_if;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_wdata_i;
    logic         cpu_stall_o;
    logic         cpu_done_o;
    logic         cpu_err_o;
    logic [31:0]  cpu_rdata_o;
    logic [31:0]  dev_addr_o;
    logic [31:0]  dev_wdata_o;
    logic [3:0]   dev_stb_o;
    logic [3:0]   dev_we_o;
    logic [3:0]   dev_ack_i;
    logic [127:0] dev_rdata_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, dev_ack_i, dev_rdata_i,
        output cpu_stall_o, cpu_done_o, cpu_err_o, cpu_rdata_o,
        output dev_addr_o, dev_wdata_o, dev_stb_o, dev_we_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, dev_ack_i, dev_rdata_i,
        input  cpu_stall_o, cpu_done_o, cpu_err_o, cpu_rdata_o,
        input  dev_addr_o, dev_wdata_o, dev_stb_o, dev_we_o
    );
endinterface

// File: rtl/io_bridge.sv
// CPU-to-MMIO bridge: decodes an access into one of 4 device windows, strobes the device,
// waits for its ack (or self-acks single-cycle devices) and returns data or an error.
//
// state  | meaning
// IDLE   | waiting for cpu_req_i; latches address/data/we/decode on request
// ACCESS | strobe to the selected device; self-ack after 1 cycle, else wait ack/timeout
// DONE   | completion pulse with read data
// ERR    | completion pulse with error (unmapped, misaligned or timed out)
module io_bridge #(
    parameter logic [127:0] DEV_BASE = {32'h7f38, 32'h7f20, 32'h7f10, 32'h7f00},
    parameter logic [127:0] DEV_MASK = {32'hfffffff8, {3{32'hfffffff0}}},
    parameter logic [3:0]   ACK_MASK = 4'b0100,
    parameter int unsigned  TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    io_bridge_if.slave  bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_next;

    logic [31:0]  r_addr;
    logic [31:0]  r_wdata;
    logic         r_we;
    logic [1:0]   r_sel_idx;
    logic [CW-1:0] r_cnt;
    logic         r_done;
    logic         r_err;
    logic [31:0]  r_rdata;

    logic         w_hit;
    logic [1:0]   w_hit_idx;
    logic         w_misaligned;
    logic         w_sel_acked;
    logic         w_ack;
    logic [3:0]   w_onehot;
    logic [31:0]  w_dev_rdata;

    // Descending scan so the lowest matching window index overrides higher ones.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if ((bus.cpu_addr_i & DEV_MASK[32*i +: 32]) == DEV_BASE[32*i +: 32]) begin
                w_hit     = 1'b1;
                w_hit_idx = 2'(i);
            end
        end
    end

    assign w_misaligned = (bus.cpu_addr_i[1:0] != 2'b00);
    assign w_sel_acked  = ACK_MASK[r_sel_idx];
    assign w_ack        = bus.dev_ack_i[r_sel_idx];
    assign w_dev_rdata  = bus.dev_rdata_i[32*r_sel_idx +: 32];

    always_comb begin
        w_onehot            = 4'b0000;
        w_onehot[r_sel_idx] = 1'b1;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.cpu_req_i) begin
                    if (w_misaligned || !w_hit) w_next = S_ERR;
                    else                        w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // An ack in the final allowed cycle still completes successfully.
                if (!w_sel_acked || w_ack)           w_next = S_DONE;
                else if (r_cnt == CW'(TIMEOUT - 1))  w_next = S_ERR;
                else                                 w_next = S_ACCESS;
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_sel_idx <= 2'd0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && bus.cpu_req_i) begin
                r_addr    <= bus.cpu_addr_i;
                r_wdata   <= bus.cpu_wdata_i;
                r_we      <= bus.cpu_we_i;
                r_sel_idx <= w_hit_idx;
                r_cnt     <= '0;
            end else if (r_state == S_ACCESS) begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_done  <= (w_next == S_DONE) || (w_next == S_ERR);
            r_err   <= (w_next == S_ERR);
            r_rdata <= (r_state == S_ACCESS && w_next == S_DONE && !r_we) ? w_dev_rdata : 32'h0;
        end
    end

    assign bus.cpu_stall_o = bus.cpu_req_i & ~r_done;
    assign bus.cpu_done_o  = r_done;
    assign bus.cpu_err_o   = r_err;
    assign bus.cpu_rdata_o = r_rdata;
    assign bus.dev_addr_o  = r_addr;
    assign bus.dev_wdata_o = r_wdata;
    assign bus.dev_stb_o   = (r_state == S_ACCESS) ? w_onehot : 4'b0000;
    assign bus.dev_we_o    = bus.dev_stb_o & {4{r_we}};

endmodule
